fp_issue_ctrl: RTL and testbench

- Issue-side partner of the pipelined FPU. Holds the decode-stage FP instruction register and the 32x32 FP register file, which is written from the FPU write-back port (wn/wd/ww).
- Drives the FPU issue inputs (a, b, fc, fd, wf). Compares source registers against the in-flight E1/E2/E3/W destination tags to forward results or raise a stall.
- Sits between the fetch stage and the FPU E1 input registers.

---
 rtl/fp_pkg.sv | 33 +++
 rtl/fp_fwd_sel.sv | 37 +++
 rtl/fp_issue_ctrl.sv | 140 ++++++++++++++
 tb/tb_fp_issue_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared types and constants for the FP issue controller.
package fp_pkg;

    localparam int unsigned FP_NREG = 32;
    localparam int unsigned FP_RW   = 5;
    localparam int unsigned FP_DW   = 32;
    localparam int unsigned FP_FCW  = 3;

    localparam logic [FP_FCW-1:0] FC_ADD = 3'b000;
    localparam logic [FP_FCW-1:0] FC_SUB = 3'b001;
    localparam logic [FP_FCW-1:0] FC_DIV = 3'b110;

    // Where a D-stage source operand comes from this cycle.
    typedef enum logic [1:0] {
        SEL_REG = 2'd0,
        SEL_WD  = 2'd1,
        SEL_ED  = 2'd2,
        SEL_HAZ = 2'd3
    } fwd_sel_e;

    // Decode-stage FP instruction register.
    typedef struct packed {
        logic              valid;
        logic [FP_RW-1:0]  fs;
        logic [FP_RW-1:0]  ft;
        logic [FP_RW-1:0]  fd;
        logic [FP_FCW-1:0] fc;
        logic              wf;
        logic              use_fs;
        logic              use_ft;
    } d_reg_t;

endpackage

// File: rtl/fp_fwd_sel.sv
// Per-source forwarding/hazard select against the in-flight FPU tags.
module fp_fwd_sel
    import fp_pkg::*;
(
    input  logic [FP_RW-1:0] src_i,
    input  logic             use_i,
    input  logic [FP_RW-1:0] e1n_i,
    input  logic             e1w_i,
    input  logic [FP_RW-1:0] e2n_i,
    input  logic             e2w_i,
    input  logic [FP_RW-1:0] e3n_i,
    input  logic             e3w_i,
    input  logic [FP_RW-1:0] wn_i,
    input  logic             ww_i,
    output fwd_sel_e         sel_c_o,
    output logic             haz_c_o
);

    // Youngest producer first: E1/E2 results are not ready, E3 and W can be bypassed.
    always_comb begin
        sel_c_o = SEL_REG;
        haz_c_o = 1'b0;
        if (use_i) begin
            if (e1w_i && (e1n_i == src_i)) begin
                sel_c_o = SEL_HAZ;
            end else if (e2w_i && (e2n_i == src_i)) begin
                sel_c_o = SEL_HAZ;
            end else if (e3w_i && (e3n_i == src_i)) begin
                sel_c_o = SEL_ED;
            end else if (ww_i && (wn_i == src_i)) begin
                sel_c_o = SEL_WD;
            end
        end
        haz_c_o = (sel_c_o == SEL_HAZ);
    end

endmodule

// File: rtl/fp_issue_ctrl.sv
// Decode-stage FP instruction register, FP register file and operand forwarding.
module fp_issue_ctrl
    import fp_pkg::*;
#(
    parameter int unsigned NREG   = 32,
    parameter int unsigned SCNT_W = 16
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              ein,
    input  logic              flush,
    input  logic              if_valid,
    input  logic [4:0]        if_fs,
    input  logic [4:0]        if_ft,
    input  logic [4:0]        if_fd,
    input  logic              if_use_fs,
    input  logic              if_use_ft,
    input  logic [2:0]        if_fc,
    input  logic              if_wf,
    input  logic [4:0]        e1n,
    input  logic [4:0]        e2n,
    input  logic [4:0]        e3n,
    input  logic [4:0]        wn,
    input  logic              e1w,
    input  logic              e2w,
    input  logic              e3w,
    input  logic              ww,
    input  logic [31:0]       ed,
    input  logic [31:0]       wd,
    output logic [31:0]       a,
    output logic [31:0]       b,
    output logic [2:0]        fc,
    output logic [4:0]        fd,
    output logic              wf,
    output logic              stall,
    output logic [SCNT_W-1:0] stall_cnt
);

    logic [FP_DW-1:0]  regs_q [NREG];
    d_reg_t            d_q, d_d;
    logic [SCNT_W-1:0] cnt_q, cnt_d;

    fwd_sel_e sel_fs, sel_ft;
    logic     haz_fs, haz_ft;

    fp_fwd_sel u_sel_fs (
        .src_i   (d_q.fs),
        .use_i   (d_q.valid & d_q.use_fs),
        .e1n_i   (e1n), .e1w_i (e1w),
        .e2n_i   (e2n), .e2w_i (e2w),
        .e3n_i   (e3n), .e3w_i (e3w),
        .wn_i    (wn),  .ww_i  (ww),
        .sel_c_o (sel_fs),
        .haz_c_o (haz_fs)
    );

    fp_fwd_sel u_sel_ft (
        .src_i   (d_q.ft),
        .use_i   (d_q.valid & d_q.use_ft),
        .e1n_i   (e1n), .e1w_i (e1w),
        .e2n_i   (e2n), .e2w_i (e2w),
        .e3n_i   (e3n), .e3w_i (e3w),
        .wn_i    (wn),  .ww_i  (ww),
        .sel_c_o (sel_ft),
        .haz_c_o (haz_ft)
    );

    assign stall = haz_fs | haz_ft;

    // Register file: write-back port is independent of the pipeline enable.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= '0;
            end
        end else if (ww) begin
            regs_q[wn] <= wd;
        end
    end

    // D register next state: flush bubbles, stall holds, otherwise load fetch.
    always_comb begin
        d_d = d_q;
        if (ein) begin
            if (flush) begin
                d_d.valid = 1'b0;
            end else if (!stall) begin
                d_d.valid  = if_valid;
                d_d.fs     = if_fs;
                d_d.ft     = if_ft;
                d_d.fd     = if_fd;
                d_d.fc     = if_fc;
                d_d.wf     = if_wf;
                d_d.use_fs = if_use_fs;
                d_d.use_ft = if_use_ft;
            end
        end
    end

    // Saturating stall-cycle counter, frozen when the pipeline is frozen.
    always_comb begin
        cnt_d = cnt_q;
        if (ein && stall && (cnt_q != {SCNT_W{1'b1}})) begin
            cnt_d = cnt_q + SCNT_W'(1);
        end
    end

    // D register and counter state.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            d_q   <= '0;
            cnt_q <= '0;
        end else begin
            d_q   <= d_d;
            cnt_q <= cnt_d;
        end
    end

    // Operand muxes; on a hazard the value is don't-care and the register is used.
    always_comb begin
        a = regs_q[d_q.fs];
        b = regs_q[d_q.ft];
        case (sel_fs)
            SEL_ED:  a = ed;
            SEL_WD:  a = wd;
            default: a = regs_q[d_q.fs];
        endcase
        case (sel_ft)
            SEL_ED:  b = ed;
            SEL_WD:  b = wd;
            default: b = regs_q[d_q.ft];
        endcase
    end

    assign fc        = d_q.fc;
    assign fd        = d_q.fd;
    assign wf        = d_q.valid & d_q.wf & ~stall;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Directed self-checking bench for fp_issue_ctrl.
module tb_fp_issue_ctrl;
    import fp_pkg::*;

    logic        clk = 1'b0;
    logic        clrn, ein, flush;
    logic        if_valid, if_use_fs, if_use_ft, if_wf;
    logic [4:0]  if_fs, if_ft, if_fd;
    logic [2:0]  if_fc;
    logic [4:0]  e1n, e2n, e3n, wn;
    logic        e1w, e2w, e3w, ww;
    logic [31:0] ed, wd;
    logic [31:0] a, b;
    logic [2:0]  fc;
    logic [4:0]  fd;
    logic        wf, stall;
    logic [15:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fp_issue_ctrl #(.NREG(32), .SCNT_W(16)) dut (
        .clk(clk), .clrn(clrn), .ein(ein), .flush(flush),
        .if_valid(if_valid), .if_fs(if_fs), .if_ft(if_ft), .if_fd(if_fd),
        .if_use_fs(if_use_fs), .if_use_ft(if_use_ft), .if_fc(if_fc), .if_wf(if_wf),
        .e1n(e1n), .e2n(e2n), .e3n(e3n), .wn(wn),
        .e1w(e1w), .e2w(e2w), .e3w(e3w), .ww(ww),
        .ed(ed), .wd(wd),
        .a(a), .b(b), .fc(fc), .fd(fd), .wf(wf), .stall(stall), .stall_cnt(stall_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_if();
        if_valid  = 1'b0;
        if_use_fs = 1'b0;
        if_use_ft = 1'b0;
        if_wf     = 1'b0;
    endtask

    task automatic set_if(input logic [4:0] fs_v, input logic ufs, input logic [4:0] ft_v,
                          input logic uft, input logic [4:0] fd_v, input logic [2:0] fc_v);
        if_valid  = 1'b1;
        if_fs     = fs_v;
        if_use_fs = ufs;
        if_ft     = ft_v;
        if_use_ft = uft;
        if_fd     = fd_v;
        if_fc     = fc_v;
        if_wf     = 1'b1;
    endtask

    task automatic test_reset();
        clrn = 1'b0; ein = 1'b1; flush = 1'b0;
        e1w = 1'b0; e2w = 1'b0; e3w = 1'b0;
        e1n = '0; e2n = '0; e3n = '0; ed = '0;
        ww = 1'b1; wn = 5'd3; wd = 32'h3f800000;
        set_if(5'd3, 1'b1, 5'd3, 1'b1, 5'd6, FC_DIV);
        if_wf = 1'b0;
        step(); step();
        checks++; if (wf !== 1'b0)       begin errors++; $display("FAIL reset_wf got=%b exp=0", wf); end
        checks++; if (stall !== 1'b0)    begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
        checks++; if (stall_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt got=%h exp=0", stall_cnt); end
        checks++; if (fc !== 3'b000)     begin errors++; $display("FAIL reset_fc got=%b exp=000", fc); end
        checks++; if (fd !== 5'd0)       begin errors++; $display("FAIL reset_fd got=%0d exp=0", fd); end
        checks++; if (a !== 32'h0 || b !== 32'h0) begin errors++; $display("FAIL reset_ab got=%h/%h exp=0/0", a, b); end
        clrn = 1'b1; ww = 1'b0;
        step();
        checks++; if (a !== 32'h0) begin errors++; $display("FAIL reset_reg3 got=%h exp=00000000", a); end
    endtask

    task automatic test_issue();
        idle_if();
        ww = 1'b1; wn = 5'd2; wd = 32'h40000000;
        step();
        wn = 5'd5; wd = 32'h40400000;
        step();
        ww = 1'b0;
        set_if(5'd2, 1'b1, 5'd5, 1'b1, 5'd7, FC_ADD);
        step();
        idle_if();
        #1;
        checks++; if (a !== 32'h40000000) begin errors++; $display("FAIL issue_a got=%h exp=40000000", a); end
        checks++; if (b !== 32'h40400000) begin errors++; $display("FAIL issue_b got=%h exp=40400000", b); end
        checks++; if (wf !== 1'b1)        begin errors++; $display("FAIL issue_wf got=%b exp=1", wf); end
        checks++; if (fd !== 5'd7)        begin errors++; $display("FAIL issue_fd got=%0d exp=7", fd); end
        checks++; if (fc !== FC_ADD)      begin errors++; $display("FAIL issue_fc got=%b exp=000", fc); end
        checks++; if (stall !== 1'b0)     begin errors++; $display("FAIL issue_stall got=%b exp=0", stall); end
    endtask

    task automatic test_back_to_back();
        set_if(5'd2, 1'b1, 5'd5, 1'b1, 5'd7, FC_SUB);
        step();
        set_if(5'd7, 1'b1, 5'd5, 1'b1, 5'd8, FC_ADD);
        step();
        e1w = 1'b1; e1n = 5'd7;
        #1;
        checks++; if (stall !== 1'b1 || wf !== 1'b0) begin errors++; $display("FAIL b2b_e1 got stall=%b wf=%b exp stall=1 wf=0", stall, wf); end
        step();
        e1w = 1'b0; e2w = 1'b1; e2n = 5'd7;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_e2 got=%b exp=1", stall); end
        step();
        e2w = 1'b0; e3w = 1'b1; e3n = 5'd7; ed = 32'h12345678;
        #1;
        checks++; if (stall !== 1'b0)       begin errors++; $display("FAIL b2b_e3_stall got=%b exp=0", stall); end
        checks++; if (a !== 32'h12345678)   begin errors++; $display("FAIL b2b_fwd_a got=%h exp=12345678", a); end
        checks++; if (b !== 32'h40400000)   begin errors++; $display("FAIL b2b_b got=%h exp=40400000", b); end
        checks++; if (wf !== 1'b1 || fd !== 5'd8) begin errors++; $display("FAIL b2b_wf got wf=%b fd=%0d exp wf=1 fd=8", wf, fd); end
        checks++; if (stall_cnt !== 16'd2)  begin errors++; $display("FAIL b2b_cnt got=%0d exp=2", stall_cnt); end
        idle_if();
        e3w = 1'b0;
        step();
    endtask

    task automatic test_bypass();
        set_if(5'd9, 1'b1, 5'd9, 1'b0, 5'd11, FC_ADD);
        step();
        idle_if();
        ww = 1'b1; wn = 5'd9; wd = 32'hc0000000;
        #1;
        checks++; if (a !== 32'hc0000000) begin errors++; $display("FAIL bypass_wd got=%h exp=c0000000", a); end
        checks++; if (b !== 32'h0 || stall !== 1'b0) begin errors++; $display("FAIL bypass_unused_ft got b=%h stall=%b exp 0/0", b, stall); end
        e3w = 1'b1; e3n = 5'd9; ed = 32'h11111111;
        #1;
        checks++; if (a !== 32'h11111111) begin errors++; $display("FAIL bypass_ed_prio got=%h exp=11111111", a); end
        e1w = 1'b1; e1n = 5'd9;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL bypass_e1_prio got=%b exp=1", stall); end
        e1w = 1'b0; e3w = 1'b0;
        step();
        ww = 1'b0;
        #1;
        checks++; if (a !== 32'hc0000000) begin errors++; $display("FAIL bypass_reg9 got=%h exp=c0000000", a); end
    endtask

    task automatic test_ein_hold();
        set_if(5'd4, 1'b1, 5'd0, 1'b0, 5'd10, FC_DIV);
        step();
        ein = 1'b0; e1w = 1'b1; e1n = 5'd4;
        set_if(5'd1, 1'b1, 5'd1, 1'b1, 5'd12, FC_SUB);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL hold_stall got=%b exp=1", stall); end
        step(); step(); step();
        checks++; if (stall !== 1'b1 || wf !== 1'b0) begin errors++; $display("FAIL hold_stall3 got stall=%b wf=%b exp 1/0", stall, wf); end
        checks++; if (fd !== 5'd10 || fc !== FC_DIV) begin errors++; $display("FAIL hold_dreg got fd=%0d fc=%b exp 10/110", fd, fc); end
        checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL hold_cnt got=%0d exp=2", stall_cnt); end
        ein = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0;
        idle_if();
        #1;
        checks++; if (wf !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL flush got wf=%b stall=%b exp 0/0", wf, stall); end
        checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL flush_cnt got=%0d exp=3", stall_cnt); end
    endtask

    task automatic test_saturate();
        set_if(5'd4, 1'b1, 5'd0, 1'b0, 5'd10, FC_ADD);
        step();
        idle_if();
        for (int i = 0; i < 65541; i++) @(posedge clk);
        #1;
        checks++; if (stall_cnt !== 16'hffff) begin errors++; $display("FAIL sat_cnt got=%h exp=ffff", stall_cnt); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sat_stall got=%b exp=1", stall); end
        clrn = 1'b0;
        step();
        clrn = 1'b1;
        #1;
        checks++; if (stall !== 1'b0 || stall_cnt !== 16'h0) begin errors++; $display("FAIL reset_mid_stall got stall=%b cnt=%h exp 0/0", stall, stall_cnt); end
        e1w = 1'b0;
    endtask

    initial begin
        test_reset();
        test_issue();
        test_back_to_back();
        test_bypass();
        test_ein_hold();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
